// File: rtl/ula_timing_gen_if.sv
// Bundle of raster timing signals between the ULA timing generator and its consumers.
interface ula_timing_gen_if;
    logic [1:0] mode;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       hblank_n;
    logic       hsync_n;
    logic       vblank_n;
    logic       vsync_n;
    logic       int_n;
    logic       border_n;
    logic       contend;
    logic       frame_start;
    logic       flash;
    logic [1:0] mode_act;

    modport master (
        input  mode,
        output hc, vc, hblank_n, hsync_n, vblank_n, vsync_n, int_n,
               border_n, contend, frame_start, flash, mode_act
    );

    modport slave (
        output mode,
        input  hc, vc, hblank_n, hsync_n, vblank_n, vsync_n, int_n,
               border_n, contend, frame_start, flash, mode_act
    );
endinterface

// File: rtl/ula_timing_gen.sv
// ULA raster timing: 48K / 128K counters, blank/sync, INT, paper and contention windows.
// Define ULA_TIMING_PENTAGON_EN to enable Pentagon timing on mode 10.
module ula_timing_gen #(
    parameter int FLASH_BITS = 5,
    parameter int INT_LEN_48 = 32
) (
    input  logic             clk7,
    input  logic             reset_n,
    ula_timing_gen_if.master bus
);

    localparam logic [1:0] MODE_48K  = 2'b00;
    localparam logic [1:0] MODE_128K = 2'b01;
`ifdef ULA_TIMING_PENTAGON_EN
    localparam logic [1:0] MODE_PENT = 2'b10;
`endif
    localparam logic [8:0] INT_END_48  = 9'(INT_LEN_48 - 1);
    localparam logic [8:0] INT_BEG_128 = 9'd4;
    localparam logic [8:0] INT_END_128 = 9'(INT_LEN_48 + 7);

    logic [8:0]            hc_q, hc_d;
    logic [8:0]            vc_q, vc_d;
    logic [8:0]            htot_m1, vtot_m1;
    logic [1:0]            mode_act_q, mode_act_d, mode_load;
    logic [FLASH_BITS-1:0] flash_cnt_q, flash_cnt_d;
    logic                  line_wrap, frame_wrap;

    logic hblank_w, hsync_w, vblank_w, vsync_w, int_w, paper_w, contend_w;
    logic hblank_n_q, hsync_n_q, vblank_n_q, vsync_n_q, int_n_q;
    logic border_n_q, contend_q, frame_start_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        htot_m1 = 9'd447;
        vtot_m1 = 9'd311;
        case (mode_act_q)
            MODE_128K: begin
                htot_m1 = 9'd455;
                vtot_m1 = 9'd310;
            end
`ifdef ULA_TIMING_PENTAGON_EN
            MODE_PENT: vtot_m1 = 9'd319;
`endif
            default: ;
        endcase
    end

    // Reserved (and Pentagon when not built in) fall back to 48K timing.
    always_comb begin
        mode_load = MODE_48K;
        if (bus.mode == MODE_128K) begin
            mode_load = MODE_128K;
        end
`ifdef ULA_TIMING_PENTAGON_EN
        else if (bus.mode == MODE_PENT) begin
            mode_load = MODE_PENT;
        end
`endif
    end

    assign line_wrap  = (hc_q == htot_m1);
    assign frame_wrap = line_wrap && (vc_q == vtot_m1);

    always_comb begin
        hc_d        = hc_q + 9'd1;
        vc_d        = vc_q;
        mode_act_d  = mode_act_q;
        flash_cnt_d = flash_cnt_q;
        if (line_wrap) begin
            hc_d = '0;
            vc_d = frame_wrap ? '0 : vc_q + 9'd1;
        end
        if (frame_wrap) begin
            mode_act_d  = mode_load;
            flash_cnt_d = flash_cnt_q + FLASH_BITS'(1);
        end
    end

    always_comb begin
        hblank_w = (hc_q >= 9'd320) && (hc_q <= 9'd415);
        hsync_w  = (hc_q >= 9'd344) && (hc_q <= 9'd375);
        vblank_w = (vc_q >= 9'd248) && (vc_q <= 9'd255);
        vsync_w  = (vc_q >= 9'd248) && (vc_q <= 9'd251);
        int_w    = (vc_q == 9'd248) && (hc_q <= INT_END_48);
        paper_w  = (vc_q < 9'd192) && !hc_q[8];
        contend_w = paper_w && (hc_q[3] || hc_q[2]);
        case (mode_act_q)
            MODE_128K: int_w = (vc_q == 9'd248) && (hc_q >= INT_BEG_128) && (hc_q <= INT_END_128);
`ifdef ULA_TIMING_PENTAGON_EN
            MODE_PENT: begin
                vblank_w  = (vc_q >= 9'd240) && (vc_q <= 9'd271);
                vsync_w   = (vc_q >= 9'd240) && (vc_q <= 9'd243);
                int_w     = (vc_q == 9'd239) && (hc_q >= 9'd320) && (hc_q <= 9'd351);
                contend_w = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) begin
            hc_q        <= '0;
            vc_q        <= '0;
            mode_act_q  <= MODE_48K;
            flash_cnt_q <= '0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            mode_act_q  <= mode_act_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // Window outputs lag the counters by one clock.
    always_ff @(posedge clk7 or negedge reset_n) begin
        if (!reset_n) begin
            hblank_n_q    <= 1'b1;
            hsync_n_q     <= 1'b1;
            vblank_n_q    <= 1'b1;
            vsync_n_q     <= 1'b1;
            int_n_q       <= 1'b1;
            border_n_q    <= 1'b1;
            contend_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hblank_n_q    <= ~hblank_w;
            hsync_n_q     <= ~hsync_w;
            vblank_n_q    <= ~vblank_w;
            vsync_n_q     <= ~vsync_w;
            int_n_q       <= ~int_w;
            border_n_q    <= paper_w;
            contend_q     <= contend_w;
            frame_start_q <= frame_wrap;
        end
    end

    assign bus.hc          = hc_q;
    assign bus.vc          = vc_q;
    assign bus.hblank_n    = hblank_n_q;
    assign bus.hsync_n     = hsync_n_q;
    assign bus.vblank_n    = vblank_n_q;
    assign bus.vsync_n     = vsync_n_q;
    assign bus.int_n       = int_n_q;
    assign bus.border_n    = border_n_q;
    assign bus.contend     = contend_q;
    assign bus.frame_start = frame_start_q;
    assign bus.flash       = flash_cnt_q[FLASH_BITS-1];
    assign bus.mode_act    = mode_act_q;

endmodule
